// File: rtl/bram_port_if.sv
// One access port of the dual-port block RAM: request fields driven by the
// client, registered read response returned by the memory.
interface bram_port_if #(
  parameter int DATA_W = 32
) ();
  logic                  en;
  logic [DATA_W/8-1:0]   wen;
  logic [31:0]           addr;
  logic [DATA_W-1:0]     din;
  logic [DATA_W-1:0]     dout;
  logic                  dvalid;
  logic                  err;

  modport master (output en, wen, addr, din, input dout, dvalid, err);
  modport slave  (input en, wen, addr, din, output dout, dvalid, err);
endinterface

// File: rtl/bram_dp.sv
// True dual-port block RAM with byte write enables, 1- or 2-cycle read latency,
// selectable read-during-write behaviour, range checking and a post-reset clear.
module bram_dp #(
  parameter int DATA_W         = 32,
  parameter int DEPTH          = 50000,
  parameter int RD_LAT         = 1,
  parameter int RDW_MODE       = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       init_busy,
  bram_port_if.slave port_a,
  bram_port_if.slave port_b
);
  localparam int BYTES = DATA_W / 8;
  localparam int BSH   = (BYTES > 1) ? $clog2(BYTES) : 0;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  typedef struct packed {
    logic              vld;
    logic              err;
    logic [DATA_W-1:0] data;
  } rd_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          clr_we;

  // Index 0 is port A, index 1 is port B.
  logic              en   [2];
  logic [BYTES-1:0]  wen  [2];
  logic [31:0]       addr [2];
  logic [DATA_W-1:0] din  [2];
  logic [31:0]       word [2];
  logic [AW-1:0]     idx  [2];
  logic [DATA_W-1:0] old  [2];
  logic [DATA_W-1:0] rd   [2];
  logic              inr  [2];
  logic              acc  [2];

  rd_t pipe_q [2][RD_LAT+1];

  function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old_w,
                                              input logic [DATA_W-1:0] new_w,
                                              input logic [BYTES-1:0]  lanes);
    logic [DATA_W-1:0] res;
    res = old_w;
    for (int i = 0; i < BYTES; i++)
      if (lanes[i]) res[8*i +: 8] = new_w[8*i +: 8];
    return res;
  endfunction

  // Clear sequencer
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal gets its default before the case so no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: ;
    endcase
  end

  assign init_busy = (state_q == ST_CLEAR);

  assign en[0]   = port_a.en;
  assign wen[0]  = port_a.wen;
  assign addr[0] = port_a.addr;
  assign din[0]  = port_a.din;
  assign en[1]   = port_b.en;
  assign wen[1]  = port_b.wen;
  assign addr[1] = port_b.addr;
  assign din[1]  = port_b.din;

  for (genvar p = 0; p < 2; p++) begin : g_dec
    assign word[p] = addr[p] >> BSH;
    assign inr[p]  = word[p] < 32'(DEPTH);
    assign idx[p]  = word[p][AW-1:0];
    assign acc[p]  = en[p] && !init_busy;
    assign old[p]  = mem[idx[p]];
    // Write-first folds this port's own lanes into the word it reads back.
    assign rd[p]   = !inr[p]            ? '0 :
                     (RDW_MODE != 0)    ? merge(old[p], din[p], wen[p]) : old[p];
  end

  // NOTE: the storage array has no reset; zeroing it is the clear sequencer's job.
  // Port B is applied first so port A's data wins on lanes both ports write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clr_we) mem[cnt_q] <= '0;
      for (int p = 1; p >= 0; p--)
        for (int i = 0; i < BYTES; i++)
          if (acc[p] && inr[p] && wen[p][i]) mem[idx[p]][8*i +: 8] <= din[p][8*i +: 8];
    end
  end

  // Read pipeline; data registers only load on a valid entry so dout holds.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int p = 0; p < 2; p++)
        for (int s = 0; s <= RD_LAT; s++) pipe_q[p][s] <= '0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        pipe_q[p][0].vld <= acc[p];
        pipe_q[p][0].err <= acc[p] && !inr[p];
        if (acc[p]) pipe_q[p][0].data <= rd[p];
        for (int s = 1; s <= RD_LAT; s++) begin
          pipe_q[p][s].vld <= pipe_q[p][s-1].vld;
          pipe_q[p][s].err <= pipe_q[p][s-1].err;
          if (pipe_q[p][s-1].vld) pipe_q[p][s].data <= pipe_q[p][s-1].data;
        end
      end
    end
  end

  assign port_a.dout   = pipe_q[0][RD_LAT].data;
  assign port_a.dvalid = pipe_q[0][RD_LAT].vld;
  assign port_a.err    = pipe_q[0][RD_LAT].err;
  assign port_b.dout   = pipe_q[1][RD_LAT].data;
  assign port_b.dvalid = pipe_q[1][RD_LAT].vld;
  assign port_b.err    = pipe_q[1][RD_LAT].err;
endmodule

// File: tb/tb_bram_dp.sv
// Directed bench for bram_dp: three instances (read-first, write-first, two-cycle
// latency) share one stimulus stream; expected values are hand-computed.
module tb_bram_dp;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_en, b_en;
  logic [3:0]  a_wen, b_wen;
  logic [31:0] a_addr, b_addr, a_din, b_din;
  logic        busy_rf, busy_wf, busy_l2;

  int n_checks = 0;
  int n_fail   = 0;

  bram_port_if #(.DATA_W(32)) rf_a (), rf_b (), wf_a (), wf_b (), l2_a (), l2_b ();

  assign {rf_a.en, rf_a.wen, rf_a.addr, rf_a.din} = {a_en, a_wen, a_addr, a_din};
  assign {rf_b.en, rf_b.wen, rf_b.addr, rf_b.din} = {b_en, b_wen, b_addr, b_din};
  assign {wf_a.en, wf_a.wen, wf_a.addr, wf_a.din} = {a_en, a_wen, a_addr, a_din};
  assign {wf_b.en, wf_b.wen, wf_b.addr, wf_b.din} = {b_en, b_wen, b_addr, b_din};
  assign {l2_a.en, l2_a.wen, l2_a.addr, l2_a.din} = {a_en, a_wen, a_addr, a_din};
  assign {l2_b.en, l2_b.wen, l2_b.addr, l2_b.din} = {b_en, b_wen, b_addr, b_din};

  bram_dp #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_rf (
    .clk(clk), .rst(rst), .init_busy(busy_rf), .port_a(rf_a), .port_b(rf_b));
  bram_dp #(.DATA_W(32), .DEPTH(16), .RD_LAT(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)) u_wf (
    .clk(clk), .rst(rst), .init_busy(busy_wf), .port_a(wf_a), .port_b(wf_b));
  bram_dp #(.DATA_W(32), .DEPTH(16), .RD_LAT(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)) u_l2 (
    .clk(clk), .rst(rst), .init_busy(busy_l2), .port_a(l2_a), .port_b(l2_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] din);
    a_en = en; a_wen = wen; a_addr = addr; a_din = din;
  endtask

  task automatic drive_b(input logic en, input logic [3:0] wen,
                         input logic [31:0] addr, input logic [31:0] din);
    b_en = en; b_wen = wen; b_addr = addr; b_din = din;
  endtask

  task automatic idle();
    drive_a(1'b0, 4'h0, 32'h0, 32'h0);
    drive_b(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic seen;

    // Reset state and clear duration
    rst = 1'b1;
    idle();
    tick();
    check("rst_dout_a",   rf_a.dout,   32'h0);
    check("rst_dvalid_b", rf_b.dvalid, 32'h0);
    check("rst_err_a",    l2_a.err,    32'h0);
    check("rst_dout_l2",  l2_b.dout,   32'h0);
    check("rst_busy",     busy_rf,     32'h1);
    rst = 1'b0;
    drive_b(1'b1, 4'hF, 32'h0, 32'hDEAD_0000);
    cyc  = 0;
    seen = 1'b0;
    while (busy_rf && cyc < 100) begin
      cyc++;
      tick();
      seen |= rf_b.dvalid | wf_b.dvalid | l2_b.dvalid;
    end
    idle();
    check("busy_cycles",   cyc,     32'd16);
    check("busy_drop",     seen,    32'h0);
    check("busy_l2_done",  busy_l2, 32'h0);

    // Sweep all words on port B, one cycle of latency
    for (int i = 0; i <= 16; i++) begin
      if (i < 16) drive_b(1'b1, 4'h0, 32'(i * 4), 32'h0);
      else        idle();
      tick();
      if (i == 0) check("sweep_dv_early", rf_b.dvalid, 32'h0);
      else begin
        check("sweep_dout",   rf_b.dout,   32'h0);
        check("sweep_dvalid", rf_b.dvalid, 32'h1);
      end
    end
    tick();
    check("sweep_dv_drop", rf_b.dvalid, 32'h0);

    // Byte lanes
    drive_a(1'b1, 4'hF, 32'h8, 32'hAABB_CCDD);
    tick();
    drive_a(1'b1, 4'h5, 32'h8, 32'h1122_3344);
    tick();
    drive_a(1'b1, 4'h0, 32'h8, 32'h0);
    tick();
    check("lane_rf_old",   rf_a.dout, 32'hAABB_CCDD);
    check("lane_wf_new",   wf_a.dout, 32'hAA22_CC44);
    idle();
    tick();
    check("lane_read",     rf_a.dout,   32'hAA22_CC44);
    check("lane_dvalid",   rf_a.dvalid, 32'h1);
    check("lane_l2_old",   l2_a.dout,   32'hAABB_CCDD);
    tick();
    check("hold_dout",     rf_a.dout,   32'hAA22_CC44);
    check("hold_dvalid",   rf_a.dvalid, 32'h0);
    check("lane_l2_read",  l2_a.dout,   32'hAA22_CC44);

    // Read-during-write, same port and cross port
    drive_a(1'b1, 4'hF, 32'h4, 32'h1);
    tick();
    drive_a(1'b1, 4'hF, 32'h4, 32'h2);
    drive_b(1'b1, 4'h0, 32'h4, 32'h0);
    tick();
    drive_a(1'b1, 4'h0, 32'h4, 32'h0);
    drive_b(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    check("rdw_rf_a",  rf_a.dout, 32'h1);
    check("rdw_wf_a",  wf_a.dout, 32'h2);
    check("rdw_rf_b",  rf_b.dout, 32'h1);
    check("rdw_wf_b",  wf_b.dout, 32'h1);
    idle();
    tick();
    check("rdw_visible", rf_a.dout, 32'h2);
    check("rdw_l2_a",    l2_a.dout, 32'h1);
    check("rdw_l2_b",    l2_b.dout, 32'h1);

    // Write collision on word 3
    drive_a(1'b1, 4'hC, 32'hC, 32'hFFFF_0000);
    drive_b(1'b1, 4'hF, 32'hC, 32'h0000_FFFF);
    tick();
    drive_a(1'b1, 4'h0, 32'hC, 32'h0);
    drive_b(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    idle();
    tick();
    check("coll_rf", rf_a.dout, 32'hFFFF_FFFF);
    check("coll_wf", wf_a.dout, 32'hFFFF_FFFF);

    // Out of range
    drive_a(1'b1, 4'hF, 32'h40, 32'hDEAD_BEEF);
    tick();
    drive_a(1'b1, 4'h0, 32'h40, 32'h0);
    tick();
    check("oor_wr_err",    rf_a.err,    32'h1);
    check("oor_wr_dout",   rf_a.dout,   32'h0);
    check("oor_wr_dvalid", rf_a.dvalid, 32'h1);
    check("oor_wr_wf",     wf_a.dout,   32'h0);
    drive_a(1'b1, 4'h0, 32'h0, 32'h0);
    tick();
    check("oor_rd_err",  rf_a.err,  32'h1);
    check("oor_rd_dout", rf_a.dout, 32'h0);
    idle();
    tick();
    check("oor_word0",     rf_a.dout, 32'h0);
    check("oor_word0_err", rf_a.err,  32'h0);
    check("oor_l2_err",    l2_a.err,  32'h1);

    // Back-to-back reads with two-cycle latency
    for (int k = 0; k < 4; k++) begin
      drive_a(1'b1, 4'hF, 32'(k * 4), 32'(16 + k));
      tick();
    end
    idle();
    tick();
    for (int i = 0; i <= 5; i++) begin
      if (i < 4) drive_b(1'b1, 4'h0, 32'(i * 4), 32'h0);
      else       idle();
      tick();
      if (i >= 1 && i <= 4) check("b2b_rf", rf_b.dout, 32'(16 + i - 1));
      if (i == 1) check("b2b_l2_early", l2_b.dvalid, 32'h0);
      if (i >= 2) begin
        check("b2b_l2_dout",   l2_b.dout,   32'(16 + i - 2));
        check("b2b_l2_dvalid", l2_b.dvalid, 32'h1);
      end
    end
    tick();
    check("b2b_l2_end", l2_b.dvalid, 32'h0);

    // Reset while reads are in flight
    seen = 1'b0;
    for (int i = 0; i <= 6; i++) begin
      if (i < 4) drive_b(1'b1, 4'h0, 32'(i * 4), 32'h0);
      else       idle();
      rst = (i == 1);
      tick();
      if (i >= 1) seen |= rf_b.dvalid | wf_b.dvalid | l2_b.dvalid;
      if (i == 1) check("mid_rst_busy", busy_l2, 32'h1);
    end
    rst = 1'b0;
    check("mid_rst_no_dvalid", seen, 32'h0);
    cyc = 0;
    while (busy_rf && cyc < 100) begin
      cyc++;
      tick();
    end
    check("mid_rst_clear_done", busy_rf, 32'h0);
    drive_a(1'b1, 4'h0, 32'hC, 32'h0);
    tick();
    idle();
    tick();
    check("recleared_rf",     rf_a.dout,   32'h0);
    check("recleared_dvalid", rf_a.dvalid, 32'h1);
    tick();
    check("recleared_l2",     l2_a.dout,   32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bram_dp.md
# bram_dp

Parametrised true dual-port block RAM for the LeNet-5 accelerator. It replaces the single-port, full-word-write buffer used for weights and feature maps. Port A serves the processor/AXI BRAM-controller side and port B serves the convolution datapath. The block adds per-byte write enables, a selectable read latency, a read-during-write mode, out-of-range detection, and a post-reset clear sequencer.

## Interface
Parameters:
- DATA_W, 32, word width in bits; multiple of 8; BYTES = DATA_W/8
- DEPTH, 50000, number of words
- RD_LAT, 1, read latency in cycles; legal values 1 or 2
- RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new data)
- CLEAR_ON_RESET, 1, 1 = zero all words after reset

Ports:
- clk  in  1  clock; all logic on its rising edge
- rst  in  1  reset; one clock, synchronous, active-high
- init_busy  out  1  clear sequencer running; both ports ignored while high
- a_en  in  1  port A access enable
- a_wen  in  BYTES  port A byte write enables; bit i writes din[8i+7:8i]
- a_addr  in  32  port A byte address; word index = a_addr >> log2(BYTES); low bits ignored
- a_din  in  DATA_W  port A write data
- a_dout  out  DATA_W  port A read data
- a_dvalid  out  1  port A read data valid, one cycle per accepted access
- a_err  out  1  port A out-of-range flag, aligned with a_dvalid
- b_en, b_wen, b_addr, b_din, b_dout, b_dvalid, b_err  same as port A, for port B

## Operation
- Accepted access: en=1 and init_busy=0. Every accepted access, read or write, performs a read of the addressed word and produces one dvalid pulse.
- Write: each byte lane with wen[i]=1 is written. wen=0 with en=1 is a pure read. Partial wen values are legal.
- Same-port read-during-write: dout returns the old word when RDW_MODE=0. When RDW_MODE=1 it returns the merged new word, with unwritten bytes keeping their old values.
- Cross-port: a read on one port of the word being written by the other port in the same cycle returns the old word.
- Write collision, same word on both ports in one cycle: lanes enabled on both ports take port A's data. Lanes enabled on only one port take that port's data.
- Out of range (word index ≥ DEPTH): the write is dropped and memory is unchanged. dout = 0 and err = 1, with the same timing as dvalid.
- Clear sequencer, with states IDLE and CLEAR:
  - rst enters CLEAR when CLEAR_ON_RESET=1, otherwise IDLE; the counter is set to 0.
  - CLEAR writes 0 to word[counter] once per cycle and increments the counter.
  - After word DEPTH-1 is written, the sequencer goes to IDLE.
  - init_busy = (state == CLEAR).
  - rst asserted mid-clear restarts the counter at 0.
  - When CLEAR_ON_RESET=0, memory contents are not affected by rst.
- Accesses presented while init_busy=1 are discarded: no write, no dvalid, no err.

## Timing
- Reset values, in the cycle after rst is sampled high:
  - a_dout, b_dout = 0
  - a_dvalid, b_dvalid, a_err, b_err = 0
  - the RD_LAT=2 pipeline stage is cleared
  - init_busy = CLEAR_ON_RESET
- Read latency: an access accepted at edge n gives dout, dvalid and err after edge n+RD_LAT. dvalid is high for exactly one cycle per access.
- Throughput: one access per port per cycle; back-to-back accesses are fully pipelined.
- Hold: dout keeps its last value when no access completes. dvalid and err return to 0.
- Write visibility: a write at edge n is visible to a read on either port accepted at edge n+1 or later.
- Clear duration: init_busy is high for exactly DEPTH cycles after rst deasserts. The first access is accepted on the cycle init_busy reads 0.
- rst during a pending read (RD_LAT=2): the in-flight result is dropped and no dvalid is issued.

## Test plan
- Reset and clear, with DEPTH=16 and CLEAR_ON_RESET=1: pulse rst, then read all 16 words on port B. Required: init_busy high for 16 cycles, every word reads 0x00000000, dvalid 1 cycle after each access.
- Byte lanes: write 0xAABBCCDD to byte address 0x8 with wen=1111, then write 0x11223344 with wen=0101. Required: a read of 0x8 returns 0xAA22CC44.
- Read-during-write: with word 0x4 = 0x1 and RDW_MODE=0, write 0x2 on port A. Required: a_dout = 0x1. Same stimulus with RDW_MODE=1 gives a_dout = 0x2. A port B read of 0x4 in the same cycle returns 0x1 in both modes.
- Collision: A writes 0xFFFF0000 (wen=1100) and B writes 0x0000FFFF (wen=1111) to word 3 in the same cycle. Required: word 3 = 0xFFFFFFFF.
- Out of range, with DEPTH=16: write to byte address 0x40, then read it. Required: err=1 and dout=0 in the dvalid cycle, and word 0 unchanged.
- RD_LAT=2: issue 4 back-to-back reads of words 0..3 holding 0x10..0x13. Required: dout = 0x10..0x13 at edges n+2..n+5 with dvalid continuously high. Asserting rst at edge n+1 suppresses every dvalid.
